// File: rtl/boid_frame_sequencer.sv
// boid_frame_sequencer
// Steps the boid memory and update datapath through one simulation frame:
// per boid LOAD -> SCAN (all neighbours) -> DRAIN -> UPDATE -> WAIT -> WRITE,
// then a one-cycle DONE that bumps the frame counter.
// Optional feature macro: BOID_SKIP_SELF_EN -- when defined, SCAN skips the
// boid's own index; when undefined, SCAN visits every index and the datapath
// is expected to mask the self term.
module boid_frame_sequencer #(
    parameter int N_BOIDS  = 2,
    parameter int W_FIELDS = 7,
    parameter int FRAME_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      dp_done,
    output logic                      busy,
    output logic                      done,
    output logic [FRAME_W-1:0]        frame_cnt,
    output logic [$clog2(N_BOIDS):0]  self_idx,
    output logic [$clog2(N_BOIDS):0]  other_idx,
    output logic                      rd_en_self,
    output logic                      rd_en_other,
    output logic                      acc_clr,
    output logic                      acc_en,
    output logic                      dp_start,
    output logic [W_FIELDS-1:0]       w_en
);

    localparam int IDX_W = $clog2(N_BOIDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BOIDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] TWO_IDX  = IDX_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        DRAIN,
        UPDATE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  self_nxt;
    logic [IDX_W-1:0]  other_nxt;
    logic [IDX_W-1:0]  scan_first;
    logic [IDX_W-1:0]  scan_last;
    logic [IDX_W-1:0]  scan_step;

`ifdef BOID_SKIP_SELF_EN
    // Scan bounds and stride that step around the boid's own index
    always_comb begin
        scan_first = (self_idx == '0) ? ONE_IDX : '0;
        scan_last  = (self_idx == LAST_IDX) ? (LAST_IDX - ONE_IDX) : LAST_IDX;
        scan_step  = ((other_idx + ONE_IDX) == self_idx) ? (other_idx + TWO_IDX)
                                                         : (other_idx + ONE_IDX);
    end
`else
    // Scan bounds and stride covering every index, self included
    always_comb begin
        scan_first = '0;
        scan_last  = LAST_IDX;
        scan_step  = other_idx + ONE_IDX;
    end
`endif

    // State, index registers, delayed accumulate strobe and frame counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            self_idx  <= '0;
            other_idx <= '0;
            acc_en    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            self_idx  <= self_nxt;
            other_idx <= other_nxt;
            // read data appears one cycle after the strobe (M10K latency)
            acc_en    <= rd_en_other;
            if (state == DONE) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    // Next-state and index sequencing
    always_comb begin
        state_nxt = state;
        self_nxt  = self_idx;
        other_nxt = other_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    self_nxt  = '0;
                end
            end
            LOAD: begin
                other_nxt = scan_first;
                state_nxt = SCAN;
            end
            SCAN: begin
                if (other_idx == scan_last) begin
                    state_nxt = DRAIN;
                end else begin
                    other_nxt = scan_step;
                end
            end
            DRAIN:  state_nxt = UPDATE;
            UPDATE: state_nxt = WAIT;
            WAIT: begin
                if (dp_done) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (self_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    self_nxt  = self_idx + ONE_IDX;
                    state_nxt = LOAD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe decode from the current state
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        rd_en_self  = 1'b0;
        rd_en_other = 1'b0;
        acc_clr     = 1'b0;
        dp_start    = 1'b0;
        w_en        = '0;
        case (state)
            IDLE: ;
            LOAD: begin
                busy       = 1'b1;
                rd_en_self = 1'b1;
                acc_clr    = 1'b1;
            end
            SCAN: begin
                busy        = 1'b1;
                rd_en_other = 1'b1;
            end
            UPDATE: begin
                busy     = 1'b1;
                dp_start = 1'b1;
            end
            WRITE: begin
                busy = 1'b1;
                w_en = '1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_boid_frame_sequencer.sv
// Testbench for boid_frame_sequencer: three instances (N=4, N=2, and a
// 2-bit frame counter with N=3) driven with randomized datapath latencies.
// Expected per-cycle strobes come from a frame trace expanded from the
// LOAD/SCAN/DRAIN/UPDATE/WAIT/WRITE/DONE timing rules.
module tb_boid_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v;
    logic [2:0] start_v;
    logic [2:0] dpd_v;

    // N=4 instance
    logic        b4_busy, b4_done, b4_rs, b4_ro, b4_clr, b4_acc, b4_dps;
    logic [15:0] b4_fc;
    logic [2:0]  b4_si, b4_oi;
    logic [6:0]  b4_wen;
    // N=2 instance
    logic        b2_busy, b2_done, b2_rs, b2_ro, b2_clr, b2_acc, b2_dps;
    logic [15:0] b2_fc;
    logic [1:0]  b2_si, b2_oi;
    logic [6:0]  b2_wen;
    // N=3, FRAME_W=2 instance
    logic        bw_busy, bw_done, bw_rs, bw_ro, bw_clr, bw_acc, bw_dps;
    logic [1:0]  bw_fc;
    logic [2:0]  bw_si, bw_oi;
    logic [2:0]  bw_wen;

    boid_frame_sequencer #(.N_BOIDS(4), .W_FIELDS(7), .FRAME_W(16)) dut4 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .dp_done(dpd_v[0]),
        .busy(b4_busy), .done(b4_done), .frame_cnt(b4_fc), .self_idx(b4_si),
        .other_idx(b4_oi), .rd_en_self(b4_rs), .rd_en_other(b4_ro),
        .acc_clr(b4_clr), .acc_en(b4_acc), .dp_start(b4_dps), .w_en(b4_wen));

    boid_frame_sequencer #(.N_BOIDS(2), .W_FIELDS(7), .FRAME_W(16)) dut2 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .dp_done(dpd_v[1]),
        .busy(b2_busy), .done(b2_done), .frame_cnt(b2_fc), .self_idx(b2_si),
        .other_idx(b2_oi), .rd_en_self(b2_rs), .rd_en_other(b2_ro),
        .acc_clr(b2_clr), .acc_en(b2_acc), .dp_start(b2_dps), .w_en(b2_wen));

    boid_frame_sequencer #(.N_BOIDS(3), .W_FIELDS(3), .FRAME_W(2)) dutw (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .dp_done(dpd_v[2]),
        .busy(bw_busy), .done(bw_done), .frame_cnt(bw_fc), .self_idx(bw_si),
        .other_idx(bw_oi), .rd_en_self(bw_rs), .rd_en_other(bw_ro),
        .acc_clr(bw_clr), .acc_en(bw_acc), .dp_start(bw_dps), .w_en(bw_wen));

    // Observed outputs of the selected instance, zero-extended
    int          sel;
    logic [31:0] o_busy, o_done, o_rs, o_ro, o_clr, o_acc, o_dps, o_fc, o_si, o_oi, o_wen;

    always_comb begin
        o_busy = '0; o_done = '0; o_rs = '0; o_ro = '0; o_clr = '0; o_acc = '0;
        o_dps = '0; o_fc = '0; o_si = '0; o_oi = '0; o_wen = '0;
        case (sel)
            0: begin
                o_busy = 32'(b4_busy); o_done = 32'(b4_done); o_rs = 32'(b4_rs);
                o_ro = 32'(b4_ro); o_clr = 32'(b4_clr); o_acc = 32'(b4_acc);
                o_dps = 32'(b4_dps); o_fc = 32'(b4_fc); o_si = 32'(b4_si);
                o_oi = 32'(b4_oi); o_wen = 32'(b4_wen);
            end
            1: begin
                o_busy = 32'(b2_busy); o_done = 32'(b2_done); o_rs = 32'(b2_rs);
                o_ro = 32'(b2_ro); o_clr = 32'(b2_clr); o_acc = 32'(b2_acc);
                o_dps = 32'(b2_dps); o_fc = 32'(b2_fc); o_si = 32'(b2_si);
                o_oi = 32'(b2_oi); o_wen = 32'(b2_wen);
            end
            default: begin
                o_busy = 32'(bw_busy); o_done = 32'(bw_done); o_rs = 32'(bw_rs);
                o_ro = 32'(bw_ro); o_clr = 32'(bw_clr); o_acc = 32'(bw_acc);
                o_dps = 32'(bw_dps); o_fc = 32'(bw_fc); o_si = 32'(bw_si);
                o_oi = 32'(bw_oi); o_wen = 32'(bw_wen);
            end
        endcase
    end

    // One expected cycle of a frame; dpd is the dp_done value the bench drives
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_self;
        logic       rd_other;
        logic       acc_clr;
        logic       acc_en;
        logic       dp_start;
        logic       wr;
        logic       dpd;
        logic [7:0] sidx;
        logic [7:0] oidx;
    } rec_t;

    rec_t trace[$];
    int   kq[8];
    int   exp_fc[3];
    int   fw_mask[3];
    int   wmask[3];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    // Expand one frame into its cycle-by-cycle expectation, cycle 1 first
    task automatic build(input int n);
        rec_t r;
        bit   first;
        trace.delete();
        for (int b = 0; b < n; b++) begin
            r = '0; r.busy = 1'b1; r.sidx = 8'(b); r.rd_self = 1'b1; r.acc_clr = 1'b1;
            trace.push_back(r);
            first = 1'b1;
            for (int j = 0; j < n; j++) begin
`ifdef BOID_SKIP_SELF_EN
                if (j == b) continue;
`endif
                r = '0; r.busy = 1'b1; r.sidx = 8'(b); r.rd_other = 1'b1;
                r.oidx = 8'(j); r.acc_en = !first;
                first = 1'b0;
                trace.push_back(r);
            end
            r = '0; r.busy = 1'b1; r.sidx = 8'(b); r.acc_en = 1'b1;
            trace.push_back(r);
            r = '0; r.busy = 1'b1; r.sidx = 8'(b); r.dp_start = 1'b1;
            trace.push_back(r);
            for (int w = 1; w <= kq[b]; w++) begin
                r = '0; r.busy = 1'b1; r.sidx = 8'(b); r.dpd = (w == kq[b]);
                trace.push_back(r);
            end
            r = '0; r.busy = 1'b1; r.sidx = 8'(b); r.wr = 1'b1;
            trace.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1; r.sidx = 8'(n - 1);
        trace.push_back(r);
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_busy"}, o_busy, 0);
        chk_eq({tag, "_done"}, o_done, 0);
        chk_eq({tag, "_frame_cnt"}, o_fc, 0);
        chk_eq({tag, "_self_idx"}, o_si, 0);
        chk_eq({tag, "_other_idx"}, o_oi, 0);
        chk_eq({tag, "_rd_en_self"}, o_rs, 0);
        chk_eq({tag, "_rd_en_other"}, o_ro, 0);
        chk_eq({tag, "_acc_clr"}, o_clr, 0);
        chk_eq({tag, "_acc_en"}, o_acc, 0);
        chk_eq({tag, "_dp_start"}, o_dps, 0);
        chk_eq({tag, "_w_en"}, o_wen, 0);
    endtask

    // Run one frame on instance s; repulse = cycle to re-pulse start (0: none);
    // abort = assert reset during a SCAN cycle of boid 1
    task automatic run_frame(input int s, input int n, input int repulse, input bit abort);
        rec_t r;
        int   dps, wrs, dn, abort_at;
        sel = s;
        build(n);
        abort_at = -1;
        if (abort) begin
            for (int i = 0; i < trace.size(); i++) begin
                if (abort_at < 0 && trace[i].rd_other && trace[i].sidx == 8'd1) abort_at = i;
            end
            abort_at = abort_at + $urandom_range(0, 1);
        end
        @(posedge clk); #1;
        chk_eq("idle_busy", o_busy, 0);
        chk_eq("idle_frame_cnt", o_fc, 32'(exp_fc[s]));
        start_v[s] = 1'b1;
        dps = 0; wrs = 0; dn = 0;
        for (int i = 0; i < trace.size(); i++) begin
            r = trace[i];
            @(posedge clk); #1;
            start_v[s] = (i + 1 == repulse);
            dpd_v[s]   = r.dpd | (r.dp_start & 1'($urandom_range(0, 1)));
            chk_eq("busy", o_busy, 32'(r.busy));
            chk_eq("done", o_done, 32'(r.done));
            chk_eq("rd_en_self", o_rs, 32'(r.rd_self));
            chk_eq("rd_en_other", o_ro, 32'(r.rd_other));
            chk_eq("acc_clr", o_clr, 32'(r.acc_clr));
            chk_eq("acc_en", o_acc, 32'(r.acc_en));
            chk_eq("dp_start", o_dps, 32'(r.dp_start));
            chk_eq("w_en", o_wen, r.wr ? 32'(wmask[s]) : 32'd0);
            chk_eq("self_idx", o_si, 32'(r.sidx));
            if (r.rd_other) chk_eq("other_idx", o_oi, 32'(r.oidx));
            chk_eq("frame_cnt", o_fc, 32'(exp_fc[s]));
            dps += int'(o_dps);
            wrs += (o_wen != 0) ? 1 : 0;
            dn  += int'(o_done);
            if (i == abort_at) begin
                #2 rst_v[s] = 1'b1;
                #1 check_zero("abort");
                start_v[s] = 1'b0;
                dpd_v[s]   = 1'b0;
                exp_fc[s]  = 0;
                repeat (2) @(posedge clk);
                #1 check_zero("abort_hold");
                rst_v[s] = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        dpd_v[s]   = 1'b0;
        exp_fc[s]  = (exp_fc[s] + 1) & fw_mask[s];
        chk_eq("dp_start_count", 32'(dps), 32'(n));
        chk_eq("write_count", 32'(wrs), 32'(n));
        chk_eq("done_count", 32'(dn), 32'd1);
        chk_eq("post_busy", o_busy, 0);
        chk_eq("post_frame_cnt", o_fc, 32'(exp_fc[s]));
        chk_eq("post_self_idx", o_si, 32'(n - 1));
    endtask

    task automatic rand_k(input int lo, input int hi);
        for (int i = 0; i < 8; i++) kq[i] = int'($urandom_range(hi, lo));
    endtask

    initial begin
        rst_v   = '1;
        start_v = '0;
        dpd_v   = '0;
        exp_fc  = '{0, 0, 0};
        fw_mask = '{32'hFFFF, 32'hFFFF, 3};
        wmask   = '{32'h7F, 32'h7F, 32'h7};
        sel     = 0;

        // Reset held: every output of every instance is zero
        repeat (3) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check_zero("reset");
        end
        #2 rst_v = '0;
        sel = 0;
        repeat (20) begin
            @(posedge clk); #1;
            check_zero("quiet");
        end

        // N=4: fixed k=3 with a stray start at cycle 10, then random latencies
        for (int i = 0; i < 8; i++) kq[i] = 3;
        run_frame(0, 4, 10, 1'b0);
        repeat (3) begin
            rand_k(1, 6);
            run_frame(0, 4, int'($urandom_range(30, 2)), 1'b0);
        end

        // N=2: abandon a frame with reset during boid 1's scan, then full frames
        rand_k(1, 4);
        run_frame(1, 2, 0, 1'b1);
        repeat (3) begin
            rand_k(1, 5);
            run_frame(1, 2, int'($urandom_range(12, 0)), 1'b0);
        end

        // FRAME_W=2: five frames with k=1 wrap the counter 1,2,3,0,1
        for (int i = 0; i < 8; i++) kq[i] = 1;
        repeat (5) run_frame(2, 3, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
